// File: rtl/note_mixer_dac_tx.sv
// Mixes the pressed note levels once per audio sample, saturates to W bits and
// streams the result MSB-first to a 3-wire serial DAC.
module note_mixer_dac_tx #(
  parameter int NUM_KEYS   = 36,
  parameter int W          = 16,
  parameter int SAMPLE_DIV = 1134,
  parameter int SCLK_HALF  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_KEYS-1:0]   key,
  input  logic [NUM_KEYS*W-1:0] notes,
  output logic                  dac_sclk,
  output logic                  dac_sync_n,
  output logic                  dac_din,
  output logic [W-1:0]          sample,
  output logic                  sample_valid,
  output logic                  clip,
  output logic                  overrun,
  output logic [2:0]            state
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int IW = $clog2(NUM_KEYS);
  localparam int AW = W + IW;
  localparam int PW = $clog2(2 * SCLK_HALF);
  localparam int BW = $clog2(W);

  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_KEYS - 1);
  localparam logic [PW-1:0] PH_RISE  = PW'(SCLK_HALF - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * SCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_SAT   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

  logic [DW-1:0]       div_cnt;
  logic [NUM_KEYS-1:0] key_q;
  logic [AW-1:0]       acc;
  logic [IW-1:0]       idx;
  logic [PW-1:0]       ph;
  logic [BW-1:0]       bit_cnt;
  logic [W-1:0]        shreg;
  logic [W-1:0]        note_sel;
  logic [W-1:0]        sat_val;
  logic                tick;
  logic                ovf;

  assign tick    = (div_cnt == DIV_LAST);
  assign ovf     = |acc[AW-1:W];
  assign sat_val = ovf ? '1 : acc[W-1:0];

  // Notes are read live during the scan; only the key vector is snapshotted.
  always_comb begin
    note_sel = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (idx == IW'(i) && key_q[i]) note_sel = notes[i*W +: W];
    end
  end

  // sample_valid is a one-cycle strobe with no ready: the consumer must take
  // sample/clip in the cycle sample_valid is high; they then hold until the next strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      state        <= ST_IDLE;
      key_q        <= '0;
      acc          <= '0;
      idx          <= '0;
      ph           <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      dac_sclk     <= 1'b0;
      dac_sync_n   <= 1'b1;
      dac_din      <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      clip         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + 1'b1;
      sample_valid <= 1'b0;
      if (tick && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            key_q <= key;
            acc   <= '0;
            idx   <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          acc <= acc + AW'(note_sel);
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) state <= ST_SAT;
        end
        ST_SAT: begin
          sample       <= sat_val;
          clip         <= ovf;
          sample_valid <= 1'b1;
          shreg        <= sat_val;
          dac_din      <= sat_val[W-1];
          dac_sync_n   <= 1'b0;
          dac_sclk     <= 1'b0;
          ph           <= '0;
          bit_cnt      <= '0;
          state        <= ST_SHIFT;
        end
        ST_SHIFT: begin
          ph <= ph + 1'b1;
          if (ph == PH_RISE) dac_sclk <= 1'b1;
          if (ph == PH_LAST) begin
            ph       <= '0;
            dac_sclk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              dac_sync_n <= 1'b1;
              dac_din    <= 1'b0;
              state      <= ST_END;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg << 1;
              dac_din <= shreg[W-2];
            end
          end
        end
        ST_END:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
